// File: rtl/usb_frame_pkg.sv
// Shared types for the USB RX frame parser.
// State encoding, default sync marker and header bundle.
package usb_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_HDR,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
  localparam logic [15:0] ERR_MAX      = 16'hFFFF;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] len;
  } hdr_t;

endpackage

// File: rtl/usb_frame_timeout.sv
// Idle-cycle counter with clear/enable; pulses o_expire on the
// LIMIT-th enabled cycle. LIMIT of 0 never expires.
module usb_frame_timeout #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [W-1:0] r_cnt;
  logic         w_hit;

  assign w_hit    = (LIMIT != 0) && i_en && (r_cnt == LAST);
  assign o_expire = w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_hit) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_frame_parser.sv
// Recovers sync/cmd/len/payload/xor-checksum frames from the
// FTDI RX byte stream and emits header, word stream and status.
module usb_frame_parser
  import usb_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [7:0]  hdr_cmd,
  output logic [7:0]  hdr_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        frame_abort,
  output logic [15:0] err_cnt
);

  state_t      r_state;
  state_t      w_next;
  hdr_t        r_hdr;
  logic [7:0]  r_csum;
  logic [1:0]  r_idx;
  logic [7:0]  r_wcnt;
  logic [23:0] r_part;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_last;
  logic        r_done;
  logic        r_ok;
  logic        r_abort;
  logic [15:0] r_err;

  logic w_acc;
  logic w_timed;
  logic w_load;
  logic w_final;
  logic w_expire;
  logic w_to_en;
  logic w_to_clr;
  logic w_err_inc;

  assign w_acc   = rx_valid & rx_ready;
  assign w_load  = (r_state == ST_PAYLOAD) && w_acc && (r_idx == 2'd3);
  assign w_final = w_load && ((r_wcnt + 8'd1) == r_hdr.len);

  assign w_to_en  = w_timed & rx_ready & ~rx_valid;
  assign w_to_clr = ~w_timed | w_acc;

  usb_frame_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_to_clr),
    .i_en     (w_to_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_expire) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:    if (w_acc && rx_data == SYNC_BYTE) w_next = ST_CMD;
        ST_CMD:     if (w_acc) w_next = ST_LEN;
        ST_LEN:     if (w_acc) w_next = ST_HDR;
        ST_HDR:     if (hdr_ready)
                      w_next = (r_hdr.len == 8'd0) ? ST_CSUM : ST_PAYLOAD;
        ST_PAYLOAD: if (w_final) w_next = ST_CSUM;
        ST_CSUM:    if (w_acc) w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // The 4th byte of a word may only enter when the output slot frees up.
  always_comb begin
    rx_ready  = 1'b0;
    hdr_valid = 1'b0;
    w_timed   = 1'b0;
    unique case (r_state)
      ST_IDLE: rx_ready = 1'b1;
      ST_CMD, ST_LEN, ST_CSUM: begin
        rx_ready = 1'b1;
        w_timed  = 1'b1;
      end
      ST_HDR: hdr_valid = 1'b1;
      ST_PAYLOAD: begin
        rx_ready = (r_idx != 2'd3) | ~r_valid | out_ready;
        w_timed  = 1'b1;
      end
      default: rx_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr  <= '0;
      r_csum <= '0;
      r_idx  <= '0;
      r_wcnt <= '0;
      r_part <= '0;
      r_done <= 1'b0;
      r_ok   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ok   <= 1'b0;
      if (w_expire) r_idx <= '0;
      case (r_state)
        ST_IDLE: if (w_acc && rx_data == SYNC_BYTE) r_csum <= '0;
        ST_CMD: if (w_acc) begin
          r_hdr.cmd <= rx_data;
          r_csum    <= r_csum ^ rx_data;
        end
        ST_LEN: if (w_acc) begin
          r_hdr.len <= rx_data;
          r_csum    <= r_csum ^ rx_data;
          r_idx     <= '0;
          r_wcnt    <= '0;
        end
        ST_PAYLOAD: if (w_acc) begin
          r_csum <= r_csum ^ rx_data;
          r_idx  <= r_idx + 2'd1;
          r_part <= {rx_data, r_part[23:8]};
          if (r_idx == 2'd3) r_wcnt <= r_wcnt + 8'd1;
        end
        ST_CSUM: if (w_acc) begin
          r_done <= 1'b1;
          r_ok   <= (rx_data == r_csum);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_data  <= {rx_data, r_part};
      r_valid <= 1'b1;
      r_last  <= w_final;
    end else if (out_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign w_err_inc = (r_done & ~r_ok) | r_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abort <= 1'b0;
      r_err   <= '0;
    end else begin
      r_abort <= w_expire;
      if (w_err_inc && r_err != ERR_MAX) r_err <= r_err + 16'd1;
    end
  end

  assign hdr_cmd     = r_hdr.cmd;
  assign hdr_len     = r_hdr.len;
  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign out_last    = r_last;
  assign frame_done  = r_done;
  assign frame_ok    = r_ok;
  assign frame_abort = r_abort;
  assign err_cnt     = r_err;

endmodule

// File: tb/tb_usb_frame_parser.sv
// Bench for usb_frame_parser: frame table plus stall, timeout,
// saturation and mid-frame reset sequences, scoreboarded.
module tb_usb_frame_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = 8'h00;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [7:0]  hdr_cmd;
  logic [7:0]  hdr_len;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        frame_done;
  logic        frame_ok;
  logic        frame_abort;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  usb_frame_parser #(
    .TIMEOUT_CYCLES (16),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .hdr_valid   (hdr_valid),
    .hdr_ready   (hdr_ready),
    .hdr_cmd     (hdr_cmd),
    .hdr_len     (hdr_len),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .frame_abort (frame_abort),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    int          npre;
    logic [7:0]  pre0;
    logic [7:0]  pre1;
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          force_csum;
    logic [7:0]  csum;
    bit          exp_ok;
    logic [15:0] exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int aborts = 0;

  logic [15:0] hdr_q[$];
  logic [32:0] word_q[$];
  bit          done_q[$];

  vec_t tbl[5];
  vec_t v_std;
  vec_t v_bad;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s got %h expected nothing", name, act);
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (frame_abort) aborts++;
      if (hdr_valid && hdr_ready) begin
        if (hdr_q.size() == 0) unexpected("hdr", {hdr_cmd, hdr_len});
        else chk("hdr", {hdr_cmd, hdr_len}, hdr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (word_q.size() == 0) begin
          unexpected("word", out_data);
        end else begin
          logic [32:0] e;
          e = word_q.pop_front();
          chk("word", out_data, e[31:0]);
          chk("last", out_last, e[32]);
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) unexpected("done", frame_ok);
        else chk("frame_ok", frame_ok, done_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] xsum(input vec_t v);
    logic [7:0]  x;
    logic [31:0] w;
    x = v.cmd ^ v.len;
    for (int i = 0; i < int'(v.len); i++) begin
      w = (i == 0) ? v.w0 : v.w1;
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    return x;
  endfunction

  // Entered at a falling edge; returns at the falling edge after accept.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      unexpected("rx_ready_wait", b);
      rx_valid = 1'b0;
    end else begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0]  c;
    logic [31:0] w;
    c = v.force_csum ? v.csum : xsum(v);
    hdr_q.push_back({v.cmd, v.len});
    for (int i = 0; i < int'(v.len); i++) begin
      w = (i == 0) ? v.w0 : v.w1;
      word_q.push_back({(i == int'(v.len) - 1), w});
    end
    done_q.push_back(v.exp_ok);
    if (v.npre > 0) send_byte(v.pre0);
    if (v.npre > 1) send_byte(v.pre1);
    send_byte(8'hA5);
    send_byte(v.cmd);
    send_byte(v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      w = (i == 0) ? v.w0 : v.w1;
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
    send_byte(c);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((hdr_q.size() + word_q.size() + done_q.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(name, hdr_q.size() + word_q.size() + done_q.size(), 0);
    hdr_q.delete();
    word_q.delete();
    done_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int n;

    tbl[0] = '{0, 8'h00, 8'h00, 8'h01, 8'h02, 32'h44332211, 32'h88776655,
               1'b0, 8'h00, 1'b1, 16'd0};
    tbl[1] = '{2, 8'h00, 8'hFF, 8'h07, 8'h00, 32'h0, 32'h0,
               1'b0, 8'h00, 1'b1, 16'd0};
    tbl[2] = '{0, 8'h00, 8'h00, 8'h01, 8'h02, 32'h44332211, 32'h88776655,
               1'b1, 8'h00, 1'b0, 16'd1};
    tbl[3] = '{0, 8'h00, 8'h00, 8'h3C, 8'h01, 32'hA5A5A5A5, 32'h0,
               1'b0, 8'h00, 1'b1, 16'd1};
    tbl[4] = '{0, 8'h00, 8'h00, 8'hFF, 8'h01, 32'h12345678, 32'h0,
               1'b1, 8'h00, 1'b0, 16'd2};
    v_std = tbl[0];
    v_bad = tbl[2];

    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_flags", {hdr_valid, out_valid, out_last, frame_done,
                      frame_ok, frame_abort}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_hdr", {hdr_cmd, hdr_len}, 0);
    chk("rst_err", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", rx_ready, 1);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i]);
      wait_drain("tbl_drain");
      chk("tbl_err_cnt", err_cnt, tbl[i].exp_err);
    end
    chk("tbl_no_abort", aborts, 0);

    // Output stall at the first word.
    out_ready = 1'b0;
    fork
      run_frame(v_std);
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (20) @(negedge clk);
        #3;
        chk("stall_rx_ready", rx_ready, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, 32'h44332211);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain("stall_drain");
    chk("stall_no_abort", aborts, 0);
    chk("stall_err_cnt", err_cnt, 2);

    // Timeout with a partial word pending.
    a0 = aborts;
    hdr_q.push_back(16'h0102);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    n = 0;
    while (aborts == a0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("abort_pulses", aborts - a0, 1);
    chk("abort_no_word", out_valid, 0);
    chk("abort_err_cnt", err_cnt, 3);
    run_frame(v_std);
    wait_drain("recover_drain");
    chk("recover_err_cnt", err_cnt, 3);

    // Saturation from a preloaded full count.
    @(negedge clk);
    force dut.r_err = 16'hFFFF;
    @(negedge clk);
    release dut.r_err;
    #3;
    chk("sat_preload", err_cnt, 16'hFFFF);
    @(negedge clk);
    run_frame(v_bad);
    wait_drain("sat_drain");
    chk("sat_err_cnt", err_cnt, 16'hFFFF);

    // Asynchronous reset with a word held on the output.
    out_ready = 1'b0;
    hdr_q.push_back(16'h0102);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_flags", {hdr_valid, out_valid, out_last, frame_done,
                       frame_ok, frame_abort}, 0);
    chk("arst_data", out_data, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_rx_ready", rx_ready, 1);
    @(negedge clk);
    hdr_q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    run_frame(v_std);
    wait_drain("post_rst_drain");
    chk("post_rst_err_cnt", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
